button_conditioner: RTL and testbench

- Upstream front-end for the stopwatch core: conditions the two raw, active-low, bouncing push-buttons (start/stop and hold) from the board.
- Synchronises each button to CLK_50MHz, debounces it, and produces a one-cycle press pulse.
- Maintains the registered run and hold-active levels that drive the stopwatch counting and display-freeze controls.

---
 rtl/button_conditioner.sv | 168 ++++++++++++++++
 tb/tb_button_conditioner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Button front-end for the stopwatch core.
// Each raw, active-low, bouncing push-button is brought into the CLK_50MHz
// domain by a two-flop synchroniser, debounced by a four-state FSM and turned
// into a single registered press pulse. The top level also keeps the run and
// hold-active levels that those pulses toggle.

module button_conditioner_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_n,
    output logic press_pulse
);

    // Last count value before a level change is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_t;

    logic             meta_reg;
    logic             sync_reg;
    deb_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             pulse_reg;

    // Two-flop synchroniser; idles high so a reset looks like "released".
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= raw_n;
            sync_reg <= meta_reg;
        end
    end

    // Debounce FSM: a level must persist DEBOUNCE_CYCLES samples to be accepted;
    // the press pulse is raised only on the PRESS_WAIT -> PRESSED transition.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= RELEASED;
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
        end else begin
            pulse_reg <= 1'b0;
            case (state_reg)
                RELEASED: begin
                    if (!sync_reg) begin
                        state_reg <= PRESS_WAIT;
                        cnt_reg   <= CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (sync_reg) begin
                        // Bounce: fall back without a pulse.
                        state_reg <= RELEASED;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= PRESSED;
                        cnt_reg   <= '0;
                        pulse_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (sync_reg) begin
                        state_reg <= RELEASE_WAIT;
                        cnt_reg   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (!sync_reg) begin
                        // Release glitch: the button is still considered held.
                        state_reg <= PRESSED;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= RELEASED;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_reg <= RELEASED;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign press_pulse = pulse_reg;

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK_50MHz,
    input  logic reset_n,
    input  logic start_stop_n,
    input  logic hold_n,
    input  logic overflow_flag,
    output logic start_stop_pulse,
    output logic hold_pulse,
    output logic run,
    output logic hold_active
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int N_BTN = 2;

    // Bit 0 is start/stop, bit 1 is hold.
    logic [N_BTN-1:0] raw_n;
    logic [N_BTN-1:0] pulse_vec;
    logic             run_reg;
    logic             hold_active_reg;

    assign raw_n = {hold_n, start_stop_n};

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            button_conditioner_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk         (CLK_50MHz),
                .reset_n     (reset_n),
                .raw_n       (raw_n[gi]),
                .press_pulse (pulse_vec[gi])
            );
        end
    endgenerate

    // Run level: overflow forces it low every cycle and masks the toggle.
    always_ff @(posedge CLK_50MHz) begin
        if (!reset_n) begin
            run_reg <= 1'b0;
        end else if (overflow_flag) begin
            run_reg <= 1'b0;
        end else if (pulse_vec[0]) begin
            run_reg <= ~run_reg;
        end
    end

    // Hold level: toggled by each accepted hold press, independent of overflow.
    always_ff @(posedge CLK_50MHz) begin
        if (!reset_n) begin
            hold_active_reg <= 1'b0;
        end else if (pulse_vec[1]) begin
            hold_active_reg <= ~hold_active_reg;
        end
    end

    assign start_stop_pulse = pulse_vec[0];
    assign hold_pulse       = pulse_vec[1];
    assign run              = run_reg;
    assign hold_active      = hold_active_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4.
// Edges are numbered by cyc; a press driven just after edge k is first
// sampled at edge E = k+1 and must pulse at edge E+5.

module tb_button_conditioner;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic start_stop_n;
    logic hold_n;
    logic overflow_flag;
    logic start_stop_pulse;
    logic hold_pulse;
    logic run;
    logic hold_active;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ss_cnt   = 0;
    int ss_last  = -1;
    int hd_cnt   = 0;
    int hd_last  = -1;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLK_50MHz        (clk),
        .reset_n          (reset_n),
        .start_stop_n     (start_stop_n),
        .hold_n           (hold_n),
        .overflow_flag    (overflow_flag),
        .start_stop_pulse (start_stop_pulse),
        .hold_pulse       (hold_pulse),
        .run              (run),
        .hold_active      (hold_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (start_stop_pulse === 1'b1) begin
            ss_cnt  = ss_cnt + 1;
            ss_last = cyc;
        end
        if (hold_pulse === 1'b1) begin
            hd_cnt  = hd_cnt + 1;
            hd_last = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive selected buttons low for n_low edges, release, wait out the release debounce.
    task automatic do_press(input bit ss, input bit hd, input int n_low, output int e);
        if (ss) start_stop_n = 1'b0;
        if (hd) hold_n = 1'b0;
        e = cyc + 1;
        step(n_low);
        start_stop_n = 1'b1;
        hold_n       = 1'b1;
        step(12);
    endtask

    initial begin
        int e;
        int e2;
        int base_ss;
        int base_hd;

        // ---- reset with both buttons held ----
        reset_n = 1'b0; start_stop_n = 1'b0; hold_n = 1'b0; overflow_flag = 1'b0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check_eq("rst_outs", {28'd0, start_stop_pulse, hold_pulse, run, hold_active}, 32'd0);
        end
        reset_n = 1'b1;
        e = cyc + 1;
        step(5);
        check_eq("rst_pulse_early", {30'd0, start_stop_pulse, hold_pulse}, 32'd0);
        step(1);
        check_eq("rst_pulse_at_e5", {30'd0, start_stop_pulse, hold_pulse}, 32'd3);
        check_eq("rst_run_before", run, 1'b0);
        step(1);
        check_eq("rst_pulse_gone", {30'd0, start_stop_pulse, hold_pulse}, 32'd0);
        check_eq("rst_levels", {30'd0, run, hold_active}, 32'd3);
        step(10);
        check_eq("rst_ss_count", ss_cnt, 1);
        check_eq("rst_hd_count", hd_cnt, 1);
        check_eq("rst_ss_edge", ss_last, e + 5);
        check_eq("rst_hd_edge", hd_last, e + 5);
        $display("reset phase: pulses at edge %0d", ss_last);
        start_stop_n = 1'b1; hold_n = 1'b1;
        step(12);
        reset_n = 1'b0;
        step(2);
        check_eq("rst2_levels", {30'd0, run, hold_active}, 32'd0);
        reset_n = 1'b1;
        step(5);

        // ---- clean press ----
        base_ss = ss_cnt;
        start_stop_n = 1'b0;
        e = cyc + 1;
        step(5);
        check_eq("clean_no_early", start_stop_pulse, 1'b0);
        step(1);
        check_eq("clean_pulse", start_stop_pulse, 1'b1);
        check_eq("clean_run_lag", run, 1'b0);
        step(1);
        check_eq("clean_pulse_1cyc", start_stop_pulse, 1'b0);
        check_eq("clean_run_on", run, 1'b1);
        step(14);
        start_stop_n = 1'b1;
        step(30);
        check_eq("clean_count", ss_cnt - base_ss, 1);
        check_eq("clean_edge", ss_last, e + 5);
        do_press(1'b1, 1'b0, 20, e);
        check_eq("clean2_count", ss_cnt - base_ss, 2);
        check_eq("clean2_edge", ss_last, e + 5);
        check_eq("clean2_run_off", run, 1'b0);
        $display("clean press phase: second pulse at edge %0d", ss_last);

        // ---- bounce rejection on hold ----
        base_hd = hd_cnt;
        for (int i = 0; i < 8; i++) begin
            hold_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(1);
        end
        hold_n = 1'b1;
        step(6);
        check_eq("bounce_alt_nopulse", hd_cnt - base_hd, 0);
        for (int i = 0; i < 3; i++) begin
            hold_n = 1'b0;
            step(3);
            hold_n = 1'b1;
            step(3);
        end
        step(6);
        check_eq("bounce_3cyc_nopulse", hd_cnt - base_hd, 0);
        check_eq("bounce_hold_level", hold_active, 1'b0);
        do_press(1'b0, 1'b1, 4, e);
        check_eq("bounce_4cyc_accept", hd_cnt - base_hd, 1);
        check_eq("bounce_4cyc_edge", hd_last, e + 5);
        check_eq("bounce_hold_on", hold_active, 1'b1);
        $display("bounce phase: minimum press accepted at edge %0d", hd_last);

        // ---- release bounce on start/stop ----
        base_ss = ss_cnt;
        start_stop_n = 1'b0;
        step(10);
        check_eq("relb_first", ss_cnt - base_ss, 1);
        check_eq("relb_run_on", run, 1'b1);
        start_stop_n = 1'b1;
        step(2);
        start_stop_n = 1'b0;
        step(10);
        check_eq("relb_glitch_nopulse", ss_cnt - base_ss, 1);
        start_stop_n = 1'b1;
        step(12);
        start_stop_n = 1'b0;
        e2 = cyc + 1;
        step(10);
        check_eq("relb_repress", ss_cnt - base_ss, 2);
        check_eq("relb_repress_edge", ss_last, e2 + 5);
        check_eq("relb_run_off", run, 1'b0);
        start_stop_n = 1'b1;
        step(12);
        $display("release bounce phase: re-press at edge %0d", ss_last);

        // ---- overflow ----
        do_press(1'b1, 1'b0, 8, e);
        check_eq("ovf_run_on", run, 1'b1);
        overflow_flag = 1'b1;
        step(1);
        check_eq("ovf_run_forced", run, 1'b0);
        base_ss = ss_cnt;
        do_press(1'b1, 1'b0, 8, e);
        check_eq("ovf_pulse_fires", ss_cnt - base_ss, 1);
        check_eq("ovf_pulse_edge", ss_last, e + 5);
        check_eq("ovf_run_stays", run, 1'b0);
        overflow_flag = 1'b0;
        step(2);
        do_press(1'b1, 1'b0, 8, e);
        check_eq("ovf_clear_run_on", run, 1'b1);
        $display("overflow phase: run=%0d after clear", run);

        // ---- simultaneous presses (run=1, hold_active=1 here) ----
        start_stop_n = 1'b0; hold_n = 1'b0;
        e = cyc + 1;
        step(6);
        check_eq("sim_pulses", {30'd0, start_stop_pulse, hold_pulse}, 32'd3);
        check_eq("sim_levels_lag", {30'd0, run, hold_active}, 32'd3);
        step(1);
        check_eq("sim_levels_toggled", {30'd0, run, hold_active}, 32'd0);
        start_stop_n = 1'b1; hold_n = 1'b1;
        step(12);
        check_eq("sim_same_edge", ss_last, hd_last);
        check_eq("sim_edge", hd_last, e + 5);
        $display("simultaneous phase: pulses at edge %0d", hd_last);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
